// File: rtl/capture_readout_pkg.sv
// Shared definitions for the capture RAM readout path: FSM state encoding and
// RAM read latency, also used by the capture writer and register file.
package capture_readout_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StFetch = 3'd1;
  localparam state_t StLatch = 3'd2;
  localparam state_t StSend  = 3'd3;
  localparam state_t StDone  = 3'd4;

  // Capture RAM port B returns data this many cycles after ram_en.
  localparam int unsigned RamRdLatency = 1;

endpackage

// File: rtl/capture_readout_if.sv
// Capture RAM read port plus the byte stream towards the link transmitter.
// master = readout engine, slave = RAM/transmitter side.
interface capture_readout_if #(
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned DATA_WIDTH = 8
);

  logic                  ram_en;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_data;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output ram_en,
    output ram_addr,
    input  ram_data,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  ram_en,
    input  ram_addr,
    output ram_data,
    input  out_data,
    output out_ready,
    input  out_valid
  );

endinterface

// File: rtl/capture_readout.sv
// Drains the capture RAM after a stop: reads `count` samples from a circular buffer
// starting at start_addr and streams them out one beat per sample.
module capture_readout
  import capture_readout_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  capture_readout_if.master     bus
);

  localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   RemOne  = (ADDR_WIDTH + 1)'(1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic [ADDR_WIDTH:0]     remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    ram_en_q, busy_q, done_q;
  logic                    xfer;

  assign xfer = out_valid_q & bus.out_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    ram_addr_d  = ram_addr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    // Abort overrides every transition; a beat accepted this cycle is simply gone.
    if (abort && (state_q != StIdle)) begin
      state_d     = StIdle;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start && !abort) begin
            addr_d      = start_addr;
            remaining_d = count;
            if (count == '0) begin
              state_d = StDone;
            end else begin
              state_d    = StFetch;
              ram_addr_d = start_addr;
            end
          end
        end
        StFetch: begin
          state_d = StLatch;
        end
        StLatch: begin
          out_data_d  = bus.ram_data;
          out_valid_d = 1'b1;
          addr_d      = addr_q + AddrOne;
          remaining_d = remaining_q - RemOne;
          state_d     = StSend;
        end
        StSend: begin
          if (xfer) begin
            out_valid_d = 1'b0;
            if (remaining_q == '0) begin
              state_d = StDone;
            end else begin
              state_d    = StFetch;
              ram_addr_d = addr_q;
            end
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      ram_addr_q  <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ram_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      ram_addr_q  <= ram_addr_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      // Status outputs are registered copies of the next state.
      ram_en_q    <= (state_d == StFetch);
      busy_q      <= (state_d != StIdle);
      done_q      <= (state_d == StDone);
    end
  end

  assign bus.ram_en    = ram_en_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_capture_readout.sv
// Directed bench for capture_readout with a 16-entry behavioural RAM (RAM[i] = A0+i).
module tb_capture_readout;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   count = '0;
  logic          busy;
  logic          done;

  capture_readout_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  capture_readout #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .start_addr(start_addr),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [16];

  always @(posedge clk) begin
    if (bus.ram_en) bus.ram_data <= mem[bus.ram_addr];
  end

  // Observed traffic log.
  logic [DW-1:0] beats[$];
  int            beat_cyc[$];
  logic [AW-1:0] addrs[$];
  int            done_cnt = 0;
  int            cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      if (bus.out_valid && bus.out_ready) begin
        beats.push_back(bus.out_data);
        beat_cyc.push_back(cyc);
      end
      if (bus.ram_en) addrs.push_back(bus.ram_addr);
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [AW-1:0] a, input logic [AW:0] c);
    start_addr = a;
    count      = c;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, done_cnt - d0, 1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!bus.out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, bus.out_valid, 1'b1);
  endtask

  initial begin
    int b0, a0, d0;
    for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
    bus.out_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ram_en", bus.ram_en, 1'b0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // 1: reset asserted while a beat is waiting in SEND
    d0 = done_cnt;
    do_start(4'd3, 5'd4);
    wait_valid("t1_reach_send", 20);
    reset = 1'b1;
    #1;
    chk("t1_valid_cleared", bus.out_valid, 1'b0);
    chk("t1_data_cleared", bus.out_data, 0);
    chk("t1_addr_cleared", bus.ram_addr, 0);
    chk("t1_en_cleared", bus.ram_en, 1'b0);
    chk("t1_busy_cleared", busy, 1'b0);
    chk("t1_done_cleared", done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("t1_busy_after", busy, 1'b0);
    chk("t1_no_done", done_cnt - d0, 0);

    // 2: four beats from address 3, ready always high
    bus.out_ready = 1'b1;
    b0 = beats.size();
    d0 = done_cnt;
    do_start(4'd3, 5'd4);
    chk("t2_busy_next", busy, 1'b1);
    chk("t2_fetch_en", bus.ram_en, 1'b1);
    chk("t2_fetch_addr", bus.ram_addr, 3);
    wait_done("t2_done", 60);
    chk("t2_nbeats", beats.size() - b0, 4);
    for (int i = 0; i < 4; i++) chk("t2_beat", beats[b0 + i], 8'hA3 + 8'(i));
    for (int i = 1; i < 4; i++) chk("t2_spacing", beat_cyc[b0 + i] - beat_cyc[b0 + i - 1], 3);
    chk("t2_busy_low", busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("t2_one_done", done_cnt - d0, 1);

    // 3: wrap past the top of the buffer
    b0 = beats.size();
    a0 = addrs.size();
    do_start(4'd14, 5'd4);
    wait_done("t3_done", 60);
    chk("t3_naddr", addrs.size() - a0, 4);
    chk("t3_addr0", addrs[a0], 14);
    chk("t3_addr1", addrs[a0 + 1], 15);
    chk("t3_addr2", addrs[a0 + 2], 0);
    chk("t3_addr3", addrs[a0 + 3], 1);
    chk("t3_beat0", beats[b0], 8'hAE);
    chk("t3_beat1", beats[b0 + 1], 8'hAF);
    chk("t3_beat2", beats[b0 + 2], 8'hA0);
    chk("t3_beat3", beats[b0 + 3], 8'hA1);

    // 4a: backpressure on the first beat
    bus.out_ready = 1'b0;
    b0 = beats.size();
    do_start(4'd3, 5'd2);
    wait_valid("t4_reach_send", 20);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_data", bus.out_data, 8'hA3);
      chk("t4_hold_valid", bus.out_valid, 1'b1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    wait_done("t4_done", 60);
    chk("t4_nbeats", beats.size() - b0, 2);
    chk("t4_beat0", beats[b0], 8'hA3);
    chk("t4_beat1", beats[b0 + 1], 8'hA4);

    // 4b: full-depth read visits every location once
    b0 = beats.size();
    a0 = addrs.size();
    do_start(4'd5, 5'd16);
    wait_done("t4b_done", 200);
    chk("t4b_nbeats", beats.size() - b0, 16);
    chk("t4b_naddr", addrs.size() - a0, 16);
    for (int i = 0; i < 16; i++) begin
      chk("t4b_addr", addrs[a0 + i], (5 + i) % 16);
      chk("t4b_beat", beats[b0 + i], 8'hA0 + 8'((5 + i) % 16));
    end

    // 5: zero-length request
    b0 = beats.size();
    a0 = addrs.size();
    d0 = done_cnt;
    do_start(4'd7, 5'd0);
    chk("t5_done_pulse", done, 1'b1);
    chk("t5_busy_in_done", busy, 1'b1);
    @(negedge clk);
    chk("t5_done_end", done, 1'b0);
    chk("t5_busy_end", busy, 1'b0);
    chk("t5_no_ram", addrs.size() - a0, 0);
    chk("t5_no_beats", beats.size() - b0, 0);
    chk("t5_done_cnt", done_cnt - d0, 1);

    // 6: start while busy is ignored, abort in the second SEND
    b0 = beats.size();
    d0 = done_cnt;
    do_start(4'd0, 5'd8);
    do_start(4'd9, 5'd3);
    while (!(beats.size() - b0 == 1 && bus.out_valid) && cyc < 100000) @(negedge clk);
    chk("t6_second_send", bus.out_valid, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t6_valid_off", bus.out_valid, 1'b0);
    chk("t6_busy_off", busy, 1'b0);
    chk("t6_en_off", bus.ram_en, 1'b0);
    chk("t6_done_off", done, 1'b0);
    repeat (5) @(negedge clk);
    chk("t6_no_done", done_cnt - d0, 0);
    chk("t6_nbeats", beats.size() - b0, 2);
    chk("t6_beat0", beats[b0], 8'hA0);
    chk("t6_beat1", beats[b0 + 1], 8'hA1);

    // 7: start and abort together in IDLE
    a0 = addrs.size();
    start_addr = 4'd2;
    count      = 5'd2;
    start      = 1'b1;
    abort      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("t7_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("t7_no_ram", addrs.size() - a0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
